// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : mem_arbiter
// Description : Two-requester (fetch / data) arbiter onto one memory port.
//               Define MEM_ARBITER_RR_EN for round-robin tie-break, else data wins.
// Revision    : 1.0
// ----------------------------------------------------------------------------
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_read,
  input  logic [15:0] i_address,
  output logic [15:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [15:0] d_address,
  input  logic [15:0] d_wdata,
  input  logic [1:0]  d_byte_enable,
  output logic [15:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic C_GRANT_I = 1'b0;
  localparam logic C_GRANT_D = 1'b1;

  state_t r_state;
  state_t w_next_state;
  logic   r_last_grant;
  logic   w_next_last_grant;
  logic   w_i_req;
  logic   w_d_req;
  logic   w_tie_to_d;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

`ifdef MEM_ARBITER_RR_EN
  assign w_tie_to_d = (r_last_grant == C_GRANT_I);
`else
  // Always true: data wins every tie; last_grant is still tracked.
  assign w_tie_to_d = (r_last_grant == C_GRANT_I) | (r_last_grant == C_GRANT_D);
`endif

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= C_GRANT_I;
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_next_last_grant;
    end
  end

  always_comb begin
    w_next_state      = r_state;
    w_next_last_grant = r_last_grant;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_address       = 16'h0000;
    mem_wdata         = 16'h0000;
    mem_byte_enable   = 2'b11;
    i_resp            = 1'b0;
    d_resp            = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_req && (!w_i_req || w_tie_to_d)) begin
          w_next_state      = SERVE_D;
          w_next_last_grant = C_GRANT_D;
        end else if (w_i_req) begin
          w_next_state      = SERVE_I;
          w_next_last_grant = C_GRANT_I;
        end
      end
      SERVE_I: begin
        mem_read    = i_read;
        mem_address = i_address;
        i_resp      = mem_resp;
        // A dropped request ends the grant just like a completion.
        if (mem_resp || !w_i_req) begin
          w_next_state = IDLE;
        end
      end
      SERVE_D: begin
        mem_read        = d_read & ~d_write;
        mem_write       = d_write;
        mem_address     = d_address;
        mem_wdata       = d_wdata;
        mem_byte_enable = d_byte_enable;
        d_resp          = mem_resp;
        if (mem_resp || !w_d_req) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a grant-order scoreboard.
// Revision    : 1.0
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam logic [15:0] C_KEY = 16'h5A5A;

  logic        clk;
  logic        reset;
  logic        i_read;
  logic [15:0] i_address;
  logic [15:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [15:0] d_address;
  logic [15:0] d_wdata;
  logic [1:0]  d_byte_enable;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  logic        auto_en;
  logic        man_resp;
  logic [15:0] man_rdata;
  logic [3:0]  r_cnt;
  logic        w_auto_resp;

  typedef struct {
    logic        is_d;
    logic [15:0] addr;
  } exp_t;
  exp_t sb[$];

  int total;
  int bad;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: completes on the third consecutive strobe cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= 4'd0;
    else if ((mem_read || mem_write) && !mem_resp) r_cnt <= r_cnt + 4'd1;
    else r_cnt <= 4'd0;
  end
  assign w_auto_resp = (mem_read || mem_write) && (r_cnt == 4'd2);
  assign mem_resp    = auto_en ? w_auto_resp : man_resp;
  assign mem_rdata   = auto_en ? (mem_address ^ C_KEY) : man_rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_read = 1'b0; i_address = 16'h0; d_read = 1'b0; d_write = 1'b0;
    d_address = 16'h0; d_wdata = 16'h0; d_byte_enable = 2'b11;
    man_resp = 1'b0; man_rdata = 16'h0;
  endtask

  task automatic wait_resp(output logic got_d, output logic [15:0] rdata,
                           output logic [15:0] addr, output logic both, output logic tmo);
    tmo = 1'b1; got_d = 1'b0; rdata = 16'h0; addr = 16'h0; both = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #2;
      if (i_resp || d_resp) begin
        got_d = d_resp;
        both  = i_resp & d_resp;
        rdata = d_resp ? d_rdata : i_rdata;
        addr  = mem_address;
        tmo   = 1'b0;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; reset = 1'b1; clear_inputs();
    @(posedge clk); #1; reset = 1'b0; sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; auto_en = 1'b0; clear_inputs(); i_read = 1'b1; d_write = 1'b1;
    d_address = 16'hFFFF; d_wdata = 16'hFFFF;
    tick(); tick(); #1;
    total++; if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b want 00", {mem_read, mem_write}); end
    total++; if (mem_address !== 16'h0 || mem_wdata !== 16'h0) begin bad++; $display("FAIL reset_addr_data: got %h/%h want 0000/0000", mem_address, mem_wdata); end
    total++; if (mem_byte_enable !== 2'b11) begin bad++; $display("FAIL reset_be: got %b want 11", mem_byte_enable); end
    total++; if ({i_resp, d_resp} !== 2'b00) begin bad++; $display("FAIL reset_resp: got %b want 00", {i_resp, d_resp}); end
    clear_inputs(); #1; reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    auto_en = 1'b0;
    tick(); i_read = 1'b1; i_address = 16'h0040; #1;
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL fetch_c0_read: got %b want 0", mem_read); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) begin man_resp = 1'b1; man_rdata = 16'h1234; end
      #1;
      total++; if (mem_read !== 1'b1 || mem_address !== 16'h0040 || mem_byte_enable !== 2'b11) begin
        bad++; $display("FAIL fetch_c%0d_strobe: got rd=%b a=%h be=%b want rd=1 a=0040 be=11", c, mem_read, mem_address, mem_byte_enable);
      end
    end
    total++; if (i_resp !== 1'b1 || i_rdata !== 16'h1234 || d_resp !== 1'b0) begin
      bad++; $display("FAIL fetch_resp: got ir=%b dat=%h dr=%b want 1 1234 0", i_resp, i_rdata, d_resp);
    end
    tick(); man_resp = 1'b0; #1;
    total++; if (mem_read !== 1'b0 || mem_address !== 16'h0) begin bad++; $display("FAIL fetch_c4_idle: got rd=%b a=%h want 0 0000", mem_read, mem_address); end
    i_read = 1'b0;
  endtask

  task automatic test_data_write();
    logic gd, bo, tm; logic [15:0] rd, ad; exp_t e;
    auto_en = 1'b1;
    tick(); d_write = 1'b1; d_address = 16'h0100; d_wdata = 16'hBEEF; d_byte_enable = 2'b01;
    sb.push_back('{1'b1, 16'h0100});
    tick(); #1;
    total++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 16'h0100 ||
                 mem_wdata !== 16'hBEEF || mem_byte_enable !== 2'b01 || i_resp !== 1'b0) begin
      bad++; $display("FAIL write_strobe: got w=%b r=%b a=%h d=%h be=%b ir=%b want 1 0 0100 beef 01 0",
                      mem_write, mem_read, mem_address, mem_wdata, mem_byte_enable, i_resp);
    end
    wait_resp(gd, rd, ad, bo, tm);
    total++;
    if (tm || sb.size() == 0) begin bad++; $display("FAIL write_resp: got timeout want d_resp"); end
    else begin
      e = sb.pop_front();
      if (gd !== e.is_d || bo !== 1'b0 || ad !== e.addr || rd !== (e.addr ^ C_KEY)) begin
        bad++; $display("FAIL write_resp: got d=%b both=%b a=%h dat=%h want d=1 both=0 a=%h dat=%h", gd, bo, ad, rd, e.addr, e.addr ^ C_KEY);
      end
    end
    tick(); clear_inputs();
  endtask

  task automatic test_tie();
    logic gd, bo, tm; logic [15:0] rd, ad; exp_t e;
    pulse_reset(); auto_en = 1'b1;
    i_read = 1'b1; i_address = 16'h0200; d_read = 1'b1; d_address = 16'h0300;
`ifdef MEM_ARBITER_RR_EN
    sb.push_back('{1'b1, 16'h0300}); sb.push_back('{1'b0, 16'h0200}); sb.push_back('{1'b1, 16'h0300});
`else
    sb.push_back('{1'b1, 16'h0300}); sb.push_back('{1'b1, 16'h0300}); sb.push_back('{1'b0, 16'h0200});
`endif
    for (int t = 0; t < 3; t++) begin
      wait_resp(gd, rd, ad, bo, tm);
      total++;
      if (tm || sb.size() == 0) begin bad++; $display("FAIL tie_%0d: got timeout want resp", t); end
      else begin
        e = sb.pop_front();
        if (gd !== e.is_d || ad !== e.addr || rd !== (e.addr ^ C_KEY)) begin
          bad++; $display("FAIL tie_%0d: got d=%b a=%h dat=%h want d=%b a=%h dat=%h", t, gd, ad, rd, e.is_d, e.addr, e.addr ^ C_KEY);
        end
      end
`ifndef MEM_ARBITER_RR_EN
      if (t == 1) begin tick(); d_read = 1'b0; end
`endif
    end
    tick(); clear_inputs();
  endtask

  task automatic test_preempt();
    logic gd, bo, tm; logic [15:0] rd, ad; exp_t e;
    auto_en = 1'b1;
    tick(); i_read = 1'b1; i_address = 16'h0600;
    tick(); d_read = 1'b1; d_address = 16'h0700;
    sb.push_back('{1'b0, 16'h0600}); sb.push_back('{1'b1, 16'h0700});
    wait_resp(gd, rd, ad, bo, tm);
    total++;
    if (tm || sb.size() == 0) begin bad++; $display("FAIL preempt_first: got timeout want i_resp"); end
    else begin
      e = sb.pop_front();
      if (gd !== e.is_d || ad !== e.addr) begin bad++; $display("FAIL preempt_first: got d=%b a=%h want d=%b a=%h", gd, ad, e.is_d, e.addr); end
    end
    tick(); i_read = 1'b0; #1;
    total++; if (mem_read !== 1'b0 || mem_address !== 16'h0) begin bad++; $display("FAIL preempt_turnaround: got rd=%b a=%h want 0 0000", mem_read, mem_address); end
    tick(); #1;
    total++; if (mem_read !== 1'b1 || mem_address !== 16'h0700) begin bad++; $display("FAIL preempt_dgrant: got rd=%b a=%h want 1 0700", mem_read, mem_address); end
    wait_resp(gd, rd, ad, bo, tm);
    total++;
    if (tm || sb.size() == 0) begin bad++; $display("FAIL preempt_second: got timeout want d_resp"); end
    else begin
      e = sb.pop_front();
      if (gd !== e.is_d || ad !== e.addr) begin bad++; $display("FAIL preempt_second: got d=%b a=%h want d=%b a=%h", gd, ad, e.is_d, e.addr); end
    end
    tick(); clear_inputs();
  endtask

  task automatic test_reset_mid();
    auto_en = 1'b0;
    tick(); d_read = 1'b1; d_write = 1'b1; d_address = 16'h0900;
    tick(); #1;
    total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL rstmid_active: got w=%b want 1", mem_write); end
    #2; reset = 1'b1; #1;
    total++; if ({mem_read, mem_write, d_resp} !== 3'b000) begin bad++; $display("FAIL rstmid_async: got r/w/dr=%b want 000", {mem_read, mem_write, d_resp}); end
    #1; reset = 1'b0; clear_inputs(); i_read = 1'b1; i_address = 16'h0500;
    tick(); #1;
    total++; if (mem_read !== 1'b1 || mem_address !== 16'h0500 || d_resp !== 1'b0) begin
      bad++; $display("FAIL rstmid_after: got rd=%b a=%h dr=%b want 1 0500 0", mem_read, mem_address, d_resp);
    end
    man_resp = 1'b1; tick(); clear_inputs(); tick();
  endtask

  task automatic test_dual_and_spurious();
    logic gd, bo, tm; logic [15:0] rd, ad; exp_t e;
    auto_en = 1'b1;
    tick(); d_read = 1'b1; d_write = 1'b1; d_address = 16'h0800; d_wdata = 16'h1111; d_byte_enable = 2'b10;
    sb.push_back('{1'b1, 16'h0800});
    tick(); #1;
    total++; if ({mem_read, mem_write} !== 2'b01 || mem_byte_enable !== 2'b10 || mem_wdata !== 16'h1111) begin
      bad++; $display("FAIL dual_strobe: got r/w=%b be=%b d=%h want 01 10 1111", {mem_read, mem_write}, mem_byte_enable, mem_wdata);
    end
    wait_resp(gd, rd, ad, bo, tm);
    total++;
    if (tm || sb.size() == 0) begin bad++; $display("FAIL dual_resp: got timeout want d_resp"); end
    else begin
      e = sb.pop_front();
      if (gd !== e.is_d || ad !== e.addr) begin bad++; $display("FAIL dual_resp: got d=%b a=%h want d=%b a=%h", gd, ad, e.is_d, e.addr); end
    end
    tick(); clear_inputs(); auto_en = 1'b0;
    tick(); man_resp = 1'b1; man_rdata = 16'hCAFE; #1;
    total++; if ({i_resp, d_resp} !== 2'b00) begin bad++; $display("FAIL spurious_resp: got %b want 00", {i_resp, d_resp}); end
    total++; if (i_rdata !== 16'hCAFE || d_rdata !== 16'hCAFE) begin bad++; $display("FAIL rdata_pass: got %h/%h want cafe/cafe", i_rdata, d_rdata); end
    tick(); #1;
    total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL spurious_idle: got r/w=%b want 00", {mem_read, mem_write}); end
    man_resp = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_fetch();
    test_data_write();
    test_tie();
    test_preempt();
    test_reset_mid();
    test_dual_and_spurious();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state is clocked on the rising edge of clk.
REQ-002 The ports SHALL be, in order:
  clk  in  1  system clock
  reset  in  1  asynchronous active-high reset
  i_read  in  1  instruction-fetch read request
  i_address  in  16  fetch address
  i_rdata  out  16  fetch read data
  i_resp  out  1  fetch transaction complete
  d_read  in  1  data read request
  d_write  in  1  data write request
  d_address  in  16  data address
  d_wdata  in  16  data write data
  d_byte_enable  in  2  data write byte mask
  d_rdata  out  16  data read data
  d_resp  out  1  data transaction complete
  mem_read  out  1  memory read strobe
  mem_write  out  1  memory write strobe
  mem_address  out  16  memory address
  mem_wdata  out  16  memory write data
  mem_byte_enable  out  2  memory byte mask
  mem_rdata  in  16  memory read data
  mem_resp  in  1  memory transaction complete

Function
REQ-003 The FSM SHALL have three states: IDLE, SERVE_I and SERVE_D.
REQ-004 In IDLE, all mem_* strobes SHALL be 0, mem_address and mem_wdata SHALL be 0x0000, and mem_byte_enable SHALL be 2'b11.
REQ-005 A fetch request (i_read) and a data request (d_read|d_write) SHALL each be evaluated in IDLE.
REQ-006 With one request pending in IDLE, the FSM SHALL move to the matching SERVE state on the next edge; the memory strobe SHALL assert one cycle after the request is first seen.
REQ-007 In SERVE_I, the outputs SHALL be mem_read=i_read, mem_write=0, mem_address=i_address and mem_byte_enable=2'b11.
REQ-008 In SERVE_D, the outputs SHALL be mem_read=d_read&~d_write, mem_write=d_write, mem_address=d_address, mem_wdata=d_wdata and mem_byte_enable=d_byte_enable.
REQ-009 If d_read and d_write are both asserted, the write SHALL win and the read SHALL be suppressed.
REQ-010 i_rdata and d_rdata SHALL both be driven with mem_rdata combinationally at all times.
REQ-011 i_resp SHALL equal mem_resp in SERVE_I, d_resp SHALL equal mem_resp in SERVE_D, and both SHALL be 0 otherwise, with zero added latency.
REQ-012 On mem_resp in a SERVE state, the FSM SHALL return to IDLE on the next edge; this always inserts one turnaround cycle between back-to-back grants.
REQ-013 The grant SHALL be held until mem_resp; a new request from the other requester SHALL NOT preempt an active grant.
REQ-014 If the owning requester drops its request before mem_resp, the strobe SHALL deassert that cycle and the FSM SHALL return to IDLE on the next edge.
REQ-015 A mem_resp received in IDLE SHALL be ignored; no resp output asserts.
REQ-016 A last_grant register SHALL record the most recently granted requester, updated on every IDLE->SERVE transition.

Reset
REQ-017 Asserting reset SHALL immediately force state to IDLE and last_grant to I, with outputs at the REQ-004 values and i_resp=d_resp=0, regardless of clk.
REQ-018 A reset asserted mid-transaction SHALL abort the transaction with no resp generated; the first grant after reset release follows REQ-006.

Configuration
REQ-019 The macro MEM_ARBITER_RR_EN SHALL select the tie-break used when both requests are pending in IDLE.
REQ-020 With MEM_ARBITER_RR_EN defined, ties SHALL be round-robin: the requester not equal to last_grant wins, so the first tie after reset goes to D.
REQ-021 Without MEM_ARBITER_RR_EN, ties SHALL use fixed priority with data always winning, and last_grant is still maintained.

Verification
REQ-022 Single fetch: i_read=1 with i_address=0x0040 at cycle 0, mem_resp=1 at cycle 3 with mem_rdata=0x1234 -> mem_read=1 on cycles 1-3, i_rdata=0x1234 and i_resp=1 at cycle 3, IDLE at cycle 4.
REQ-023 Data write: d_write=1, d_address=0x0100, d_wdata=0xBEEF, d_byte_enable=2'b01 -> mem_write=1 with matching address, data and mask; d_resp follows mem_resp; i_resp stays 0.
REQ-024 Simultaneous requests held for two transactions -> with RR_EN, order is D then I; without RR_EN, order is D then D while d_read stays high, with I starved until d_read drops.
REQ-025 Preemption attempt: d_read rises during SERVE_I -> the grant stays with I until mem_resp, then D is granted after one IDLE cycle.
REQ-026 Reset pulsed between clk edges during SERVE_D -> mem_read and mem_write fall to 0 asynchronously, d_resp is never asserted, and after release i_read=1 is served within 1 cycle.
REQ-027 Dual strobe: d_read=d_write=1 -> only mem_write asserts. Spurious mem_resp in IDLE -> i_resp=d_resp=0.
